mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Request arbiter between the instruction-fetch requester (icache) and the load/store requester (LSB), driving the single transaction port of the byte-serial memory controller.
- Grants one whole transaction at a time and latches its fields.
- Returns read data and a completion pulse to the owner.
- Handles fetch rollback on misprediction and stalls stores to UART while the UART buffer is full.

Parameters:
- ADDR_W, 32, address width on all ports.
- IO_BASE, 32'h00030000, addresses >= IO_BASE are memory-mapped I/O.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; low = pause
- rollback  in  1  misprediction flush; cancels instruction fetch only
- io_buffer_full  in  1  UART buffer full
- ic_valid  in  1  fetch request, held until ic_done
- ic_addr  in  ADDR_W  fetch address
- ic_done  out  1  one-cycle completion pulse
- ic_data  out  32  fetched word, valid with ic_done
- lsb_valid  in  1  load/store request, held until lsb_done
- lsb_wr  in  1  0 load, 1 store
- lsb_addr  in  ADDR_W  address
- lsb_wdata  in  32  store data
- lsb_len  in  2  bytes minus 1 (0=byte, 1=half, 3=word)
- lsb_done  out  1  one-cycle completion pulse
- lsb_rdata  out  32  load data, zero-extended raw bytes, valid with lsb_done
- mc_valid  out  1  transaction request to memory controller
- mc_wr  out  1  latched write flag
- mc_addr  out  ADDR_W  latched address
- mc_wdata  out  32  latched store data
- mc_len  out  2  latched length (3 for fetch)
- mc_done  in  1  controller completion, one cycle
- mc_rdata  in  32  controller read data, valid with mc_done

Behaviour:
- Reset: state=IDLE, last_grant=LSB (so the first tie goes to ic). All outputs are 0.
- States: IDLE, BUSY_IC, BUSY_LSB, DROP.
- rdy=0: state, mc_* outputs and last_grant hold. ic_done and lsb_done forced to 0. No sampling of mc_done occurs; the controller is paused by the same rdy.
- Eligibility in IDLE:
  - ic eligible = ic_valid & ~rollback.
  - lsb eligible = lsb_valid & ~(lsb_wr & lsb_addr>=IO_BASE & io_buffer_full).
- Round-robin arbitration: if both are eligible, grant the one not equal to last_grant. Otherwise grant the one that is eligible.
- On grant edge:
  - Latch fields into mc_*.
  - mc_valid<=1.
  - last_grant<=winner.
  - State -> BUSY_IC or BUSY_LSB.
- For a fetch grant: mc_wr=0, mc_len=3, mc_wdata=0.
- mc_valid stays 1 and mc_* stay stable until the edge on which mc_done=1 is sampled. On that edge mc_valid<=0 and state->IDLE.
- BUSY_IC + mc_done: ic_data<=mc_rdata, ic_done<=1 for one cycle.
- BUSY_LSB + mc_done:
  - Load: lsb_rdata<=mc_rdata masked to (mc_len+1) bytes, upper bytes zeroed. Arbiter masks even if the controller already did.
  - Store: lsb_rdata unchanged.
  - lsb_done<=1 for one cycle.
- Minimum one IDLE cycle between transactions. A grant never coincides with a done pulse edge.
- Rollback:
  - In BUSY_IC -> DROP. Stays DROP if mc_done is seen on the same edge? No: if mc_done=1 on that edge, go to IDLE with no ic_done.
  - DROP keeps mc_valid until mc_done, then IDLE. ic_done is never pulsed for the dropped fetch.
  - Rollback in BUSY_LSB or DROP has no effect.
  - Rollback in IDLE suppresses an ic grant that cycle.
- An IO store blocked by io_buffer_full is not eligible. ic may be granted meanwhile. The LSB is granted on the first IDLE cycle with io_buffer_full=0, subject to round-robin.
- io_buffer_full changing during BUSY_LSB has no effect; the controller handles in-transaction stalling.
- Requests dropped by a requester before done are undefined, except a fetch under rollback.
- rst asserted mid-transaction returns to reset values on that edge. The controller resets on the same rst.

Optional Feature:
- MEM_ARB_FIXED_PRIO_EN defined: LSB always wins when both are eligible; last_grant is still updated but unused.
- Not defined: round-robin as above.
- Eligibility, rollback and IO-stall rules are identical either way.

Test Plan:
- Reset, then ic_valid=1, ic_addr=0x100, lsb idle. Controller returns mc_done with mc_rdata=0x00C50513 after 5 cycles -> mc_addr=0x100, mc_len=3 the cycle after grant. ic_done=1 exactly one cycle with ic_data=0x00C50513. State IDLE for one cycle before any new grant.
- ic and lsb (load 0x2000, len=1) held continuously -> grants alternate ic, lsb, ic, lsb. Load with mc_rdata=0xDEADBEEF returns lsb_rdata=0x0000BEEF. With MEM_ARB_FIXED_PRIO_EN, the lsb load is granted first.
- Fetch 0x200 in flight, rollback pulsed one cycle, mc_done 3 cycles later -> ic_done never asserts. mc_valid held until mc_done. Next pending lsb request is granted after the IDLE cycle.
- Store to 0x30000 with io_buffer_full=1 for 10 cycles, ic fetching meanwhile -> no lsb grant while full. Grant on the first IDLE cycle after full drops, with mc_wr=1, mc_wdata=lsb_wdata, mc_len=0.
- rdy=0 for 4 cycles during BUSY_LSB with mc_done held high -> no state change, no lsb_done. lsb_done asserts once after rdy returns.
- rst asserted during BUSY_IC -> next cycle all outputs 0, state IDLE. A simultaneous ic/lsb request then grants ic first.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates icache fetches and LSB loads/stores onto the single byte-serial memory controller port.
// Define MEM_ARB_FIXED_PRIO_EN to let the LSB always win ties; otherwise ties are round-robin.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] IO_BASE = 'h0003_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rollback,
    input  logic              io_buffer_full,
    input  logic              ic_valid,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_done,
    output logic [31:0]       ic_data,
    input  logic              lsb_valid,
    input  logic              lsb_wr,
    input  logic [ADDR_W-1:0] lsb_addr,
    input  logic [31:0]       lsb_wdata,
    input  logic [1:0]        lsb_len,
    output logic              lsb_done,
    output logic [31:0]       lsb_rdata,
    output logic              mc_valid,
    output logic              mc_wr,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [31:0]       mc_wdata,
    output logic [1:0]        mc_len,
    input  logic              mc_done,
    input  logic [31:0]       mc_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY_IC, BUSY_LSB, DROP} state_t;

    state_t      state;
    state_t      state_next;
    logic        last_lsb;
    logic        ic_elig;
    logic        lsb_elig;
    logic        io_store;
    logic        grant_ok;
    logic        lsb_first;
    logic        pick_ic;
    logic        pick_lsb;
    logic        finish_ic;
    logic        finish_lsb;
    logic [31:0] load_data;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else if (rdy)
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pick_ic)
                    state_next = BUSY_IC;
                else if (pick_lsb)
                    state_next = BUSY_LSB;
            end
            BUSY_IC: begin
                if (mc_done)
                    state_next = IDLE;
                else if (rollback)
                    state_next = DROP;
            end
            BUSY_LSB, DROP: begin
                if (mc_done)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // No grant while a done pulse is showing: the owner still holds its request that cycle.
    always_comb begin
        ic_elig  = ic_valid & ~rollback;
        io_store = lsb_wr & (lsb_addr >= IO_BASE);
        lsb_elig = lsb_valid & ~(io_store & io_buffer_full);
        grant_ok = (state == IDLE) & ~ic_done & ~lsb_done;
`ifdef MEM_ARB_FIXED_PRIO_EN
        lsb_first = 1'b1;
`else
        lsb_first = ~last_lsb;
`endif
        pick_lsb   = grant_ok & lsb_elig & (~ic_elig | lsb_first);
        pick_ic    = grant_ok & ic_elig & ~pick_lsb;
        finish_ic  = (state == BUSY_IC) & mc_done & ~rollback;
        finish_lsb = (state == BUSY_LSB) & mc_done;
    end

    always_comb begin
        load_data = '0;
        for (int b = 0; b < 4; b++) begin
            if (b <= int'(mc_len))
                load_data[8*b +: 8] = mc_rdata[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mc_valid  <= 1'b0;
            mc_wr     <= 1'b0;
            mc_addr   <= '0;
            mc_wdata  <= '0;
            mc_len    <= 2'd0;
            ic_done   <= 1'b0;
            ic_data   <= '0;
            lsb_done  <= 1'b0;
            lsb_rdata <= '0;
            last_lsb  <= 1'b1;
        end else if (!rdy) begin
            ic_done  <= 1'b0;
            lsb_done <= 1'b0;
        end else begin
            ic_done  <= finish_ic;
            lsb_done <= finish_lsb;
            if (pick_ic) begin
                mc_valid <= 1'b1;
                mc_wr    <= 1'b0;
                mc_addr  <= ic_addr;
                mc_wdata <= '0;
                mc_len   <= 2'd3;
                last_lsb <= 1'b0;
            end else if (pick_lsb) begin
                mc_valid <= 1'b1;
                mc_wr    <= lsb_wr;
                mc_addr  <= lsb_addr;
                mc_wdata <= lsb_wdata;
                mc_len   <= lsb_len;
                last_lsb <= 1'b1;
            end else if (mc_done && state != IDLE) begin
                mc_valid <= 1'b0;
            end
            if (finish_ic)
                ic_data <= mc_rdata;
            if (finish_lsb && !mc_wr)
                lsb_rdata <= load_data;
        end
    end

endmodule
